// File: rtl/oq_regs_eval_status.sv
// oq_regs_eval_status
// Per-queue empty/full flag tracker for the output-queue register block.
// Two result ports (src, dst) report packet counts for a queue whose index
// was latched earlier by an *_update pulse. At most one flag write lands per
// cycle. A dst result that cannot be written at once is parked in a
// one-entry pending slot. A queue-clear (initialize) that loses arbitration
// is parked in a one-entry latch.
//
// Handshake: every input event is a single-cycle pulse with no back-pressure.
// *_update captures the queue index. *_done presents a result for the index
// captured before that cycle's edge. initialize presents a queue clear. The
// block never stalls a source. A dst result that finds the pending slot
// occupied and not draining is dropped, and this sets o_dst_drop_err.
module oq_regs_eval_status #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
    parameter int PKTS_IN_RAM_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,

    input  logic                         i_dst_update,
    input  logic [NUM_OQ_WIDTH-1:0]      i_dst_oq,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] i_dst_num_pkts_in_q,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] i_dst_max_pkts_in_q,
    input  logic                         i_dst_num_pkts_in_q_done,

    input  logic                         i_src_update,
    input  logic [NUM_OQ_WIDTH-1:0]      i_src_oq,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] i_src_num_pkts_in_q,
    input  logic [PKTS_IN_RAM_WIDTH-1:0] i_src_max_pkts_in_q,
    input  logic                         i_src_num_pkts_in_q_done,

    input  logic                         i_initialize,
    input  logic [NUM_OQ_WIDTH-1:0]      i_initialize_oq,

    input  logic                         i_err_clear,

    output logic [NUM_OUTPUT_QUEUES-1:0] o_empty,
    output logic [NUM_OUTPUT_QUEUES-1:0] o_full,
    output logic                         o_dst_drop_err
);

    // Held queue indices, one per result port
    logic [NUM_OQ_WIDTH-1:0]      r_dst_oq;
    logic [NUM_OQ_WIDTH-1:0]      r_src_oq;

    // Pending dst result slot
    logic                         r_pend_valid;
    logic [NUM_OQ_WIDTH-1:0]      r_pend_oq;
    logic                         r_pend_empty;
    logic                         r_pend_full;

    // Latched initialize request
    logic                         r_init_valid;
    logic [NUM_OQ_WIDTH-1:0]      r_init_oq;

    // Flag storage and sticky error
    logic [NUM_OUTPUT_QUEUES-1:0] r_empty;
    logic [NUM_OUTPUT_QUEUES-1:0] r_full;
    logic                         r_drop_err;

    // Combinational arbitration results
    logic                         w_src_is_empty;
    logic                         w_src_is_full;
    logic                         w_dst_is_empty;
    logic                         w_dst_is_full;
    logic                         w_init_hits_pend;
    logic                         w_pend_live;
    logic                         w_pend_drain;
    logic                         w_dst_direct;
    logic                         w_dst_to_slot;
    logic                         w_dst_drop;
    logic                         w_init_apply;
    logic                         w_wr_en;
    logic [NUM_OQ_WIDTH-1:0]      w_wr_oq;
    logic                         w_wr_empty;
    logic                         w_wr_full;
    logic [NUM_OUTPUT_QUEUES-1:0] w_empty_next;
    logic [NUM_OUTPUT_QUEUES-1:0] w_full_next;

    // Classify results and decide which single event owns the flag write port
    always_comb begin
        w_src_is_empty = (i_src_num_pkts_in_q == '0);
        w_src_is_full  = (i_src_num_pkts_in_q >= i_src_max_pkts_in_q);
        w_dst_is_empty = (i_dst_num_pkts_in_q == '0);
        w_dst_is_full  = (i_dst_num_pkts_in_q >= i_dst_max_pkts_in_q);

        // An initialize aimed at the parked queue makes the parked result stale
        w_init_hits_pend = r_pend_valid && i_initialize && (i_initialize_oq == r_pend_oq);
        w_pend_live      = r_pend_valid && !w_init_hits_pend;
        w_pend_drain     = w_pend_live && !i_src_num_pkts_in_q_done;

        w_dst_direct  = i_dst_num_pkts_in_q_done && !i_src_num_pkts_in_q_done && !w_pend_live;
        w_dst_to_slot = i_dst_num_pkts_in_q_done && !w_dst_direct && (w_pend_drain || !w_pend_live);
        w_dst_drop    = i_dst_num_pkts_in_q_done && !w_dst_direct && !w_dst_to_slot;

        // Initialize only gets the port when nothing above it wants it
        w_init_apply = !i_src_num_pkts_in_q_done && !w_pend_live && !i_dst_num_pkts_in_q_done
                       && (r_init_valid || i_initialize);

        w_wr_en    = 1'b0;
        w_wr_oq    = '0;
        w_wr_empty = 1'b0;
        w_wr_full  = 1'b0;
        if (i_src_num_pkts_in_q_done) begin
            w_wr_en    = 1'b1;
            w_wr_oq    = r_src_oq;
            w_wr_empty = w_src_is_empty;
            w_wr_full  = w_src_is_full;
        end else if (w_pend_live) begin
            w_wr_en    = 1'b1;
            w_wr_oq    = r_pend_oq;
            w_wr_empty = r_pend_empty;
            w_wr_full  = r_pend_full;
        end else if (i_dst_num_pkts_in_q_done) begin
            w_wr_en    = 1'b1;
            w_wr_oq    = r_dst_oq;
            w_wr_empty = w_dst_is_empty;
            w_wr_full  = w_dst_is_full;
        end else if (w_init_apply) begin
            // The older latched request goes first; a fresh one is latched behind it
            w_wr_en    = 1'b1;
            w_wr_oq    = r_init_valid ? r_init_oq : i_initialize_oq;
            w_wr_empty = 1'b1;
            w_wr_full  = 1'b0;
        end
    end

    // Build next flag vectors; an out-of-range index matches no queue bit
    always_comb begin
        w_empty_next = r_empty;
        w_full_next  = r_full;
        for (int q = 0; q < NUM_OUTPUT_QUEUES; q++) begin
            if (w_wr_en && (int'(w_wr_oq) == q)) begin
                w_empty_next[q] = w_wr_empty;
                w_full_next[q]  = w_wr_full;
            end
        end
    end

    // State update: held indices, pending slot, init latch, flags, sticky error
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dst_oq     <= '0;
            r_src_oq     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_oq    <= '0;
            r_pend_empty <= 1'b0;
            r_pend_full  <= 1'b0;
            r_init_valid <= 1'b0;
            r_init_oq    <= '0;
            r_empty      <= '1;
            r_full       <= '0;
            r_drop_err   <= 1'b0;
        end else begin
            if (i_dst_update) begin
                r_dst_oq <= i_dst_oq;
            end
            if (i_src_update) begin
                r_src_oq <= i_src_oq;
            end

            if (w_dst_to_slot) begin
                r_pend_valid <= 1'b1;
                r_pend_oq    <= r_dst_oq;
                r_pend_empty <= w_dst_is_empty;
                r_pend_full  <= w_dst_is_full;
            end else if (w_pend_drain || w_init_hits_pend) begin
                r_pend_valid <= 1'b0;
            end

            if (i_initialize) begin
                // Fresh request is latched unless it was the one written this cycle
                r_init_valid <= !(w_init_apply && !r_init_valid);
                r_init_oq    <= i_initialize_oq;
            end else if (w_init_apply) begin
                r_init_valid <= 1'b0;
            end

            r_empty    <= w_empty_next;
            r_full     <= w_full_next;
            r_drop_err <= w_dst_drop || (r_drop_err && !i_err_clear);
        end
    end

    assign o_empty        = r_empty;
    assign o_full         = r_full;
    assign o_dst_drop_err = r_drop_err;

endmodule
